pipe_adder: RTL

- Parametrised, pipelined successor to the single-cycle datapath adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained chunks, one chunk per cycle.
- Transactions move through the pipeline under a valid/ready handshake.
- Sits in the execute path as the ADD/ADC/SUB/SBC engine and produces ARM-style NZCV flags aligned with each result.

---
 rtl/pipe_adder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract engine, one carry-chained chunk per stage, valid/ready flow.
// Optional NZCV flag generation is built only when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic [3:0]       flags_out
);

    localparam int CW = WIDTH / STAGES;

    generate
        if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
            $error("pipe_adder: STAGES must be >= 1 and divide WIDTH evenly");
        end
    endgenerate

    logic [WIDTH-1:0] b_eff;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] v_p;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];

    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic             c_p   [STAGES];

    logic [WIDTH-1:0] sum_n [STAGES];
    logic             c_n   [STAGES];

    assign b_eff = sub_in ? ~b_in : b_in;

    // A stage can move on when its consumer takes data or any stage downstream has a hole.
    always_comb begin
        logic [STAGES-1:0] above;
        for (int k = 0; k < STAGES; k++) begin
            above  = {STAGES{1'b1}} << (k + 1);
            adv[k] = out_ready || (|(~v_q & above));
            ld[k]  = v_p[k] && (!v_q[k] || adv[k]);
        end
    end

    assign in_ready  = !v_q[0] || adv[0];
    assign out_valid = v_q[STAGES-1];
    assign sum_out   = sum_q[STAGES-1];

`ifdef PIPE_ADDER_FLAGS_EN
    logic             z_q [STAGES];
    logic             z_p [STAGES];
    logic             z_n [STAGES];
    logic [3:0]       flags_q;
    logic [3:0]       flags_n;
    logic             msb_n;
`endif

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [CW:0]      add_r;
            logic [WIDTH-1:0] sum_full;

            if (k == 0) begin : g_first
                assign v_p[k]   = in_valid;
                assign a_p[k]   = a_in;
                assign b_p[k]   = b_eff;
                assign sum_p[k] = '0;
                assign c_p[k]   = carry_in;
`ifdef PIPE_ADDER_FLAGS_EN
                assign z_p[k]   = 1'b1;
`endif
            end else begin : g_next
                assign v_p[k]   = v_q[k-1];
                assign a_p[k]   = a_q[k-1];
                assign b_p[k]   = b_q[k-1];
                assign sum_p[k] = sum_q[k-1];
                assign c_p[k]   = c_q[k-1];
`ifdef PIPE_ADDER_FLAGS_EN
                assign z_p[k]   = z_q[k-1];
`endif
            end

            assign add_r = {1'b0, a_p[k][k*CW +: CW]}
                         + {1'b0, b_p[k][k*CW +: CW]}
                         + {{CW{1'b0}}, c_p[k]};

            // Lower chunks pass through untouched; only this stage's chunk is filled in.
            always_comb begin
                sum_full                = sum_p[k];
                sum_full[k*CW +: CW]    = add_r[CW-1:0];
            end

            assign sum_n[k] = sum_full;
            assign c_n[k]   = add_r[CW];
`ifdef PIPE_ADDER_FLAGS_EN
            assign z_n[k]   = z_p[k] && (add_r[CW-1:0] == '0);
`endif
        end
    endgenerate

`ifdef PIPE_ADDER_FLAGS_EN
    assign msb_n   = sum_n[STAGES-1][WIDTH-1];
    assign flags_n = {msb_n,
                      z_n[STAGES-1],
                      c_n[STAGES-1],
                      (a_p[STAGES-1][WIDTH-1] == b_p[STAGES-1][WIDTH-1]) &&
                      (msb_n != a_p[STAGES-1][WIDTH-1])};
    assign flags_out = flags_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
            for (int i = 0; i < STAGES; i++) begin
                z_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (ld[i]) begin
                    z_q[i] <= z_n[i];
                end
            end
            if (ld[STAGES-1]) begin
                flags_q <= flags_n;
            end
        end
    end
`else
    assign flags_out = 4'b0000;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
                c_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (!v_q[i] || adv[i]) begin
                    v_q[i] <= v_p[i];
                end
                if (ld[i]) begin
                    a_q[i]   <= a_p[i];
                    b_q[i]   <= b_p[i];
                    sum_q[i] <= sum_n[i];
                    c_q[i]   <= c_n[i];
                end
            end
        end
    end

endmodule
